// File: rtl/multi_ch_digital_gain_pkg.sv
// Shared constants and width helpers for the multi-channel digital gain block.
package gkt_dsp_pkg;
  localparam int COEFF_W  = 16;
  localparam int PROD_EXT = COEFF_W + 1;  // zero-extended coeff adds a sign bit
  localparam logic [7:0] DEF_SIGNED_MASK = 8'b0000_1110;

  function automatic int cnt_w(input int fft_point);
    return $clog2(fft_point) + 2;
  endfunction

  function automatic int prod_w(input int in_w);
    return in_w + PROD_EXT;
  endfunction
endpackage

// File: rtl/multi_ch_digital_gain_if.sv
// Sample/coeff bus of the gain block; slave is the DUT side.
interface multi_ch_digital_gain_if import gkt_dsp_pkg::*; #(
  parameter int NCH   = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 11
);
  logic [NCH-1:0][COEFF_W-1:0] scaled_coeff;
  logic                        en_sync_in;
  logic [CNT_W-1:0]            cnt_sync_in;
  logic [NCH-1:0][IN_W-1:0]    para_in;
  logic                        en_sync_out;
  logic [CNT_W-1:0]            cnt_sync_out;
  logic [NCH-1:0][OUT_W-1:0]   para_out;
  logic [NCH-1:0][IN_W-1:0]    max_out;
  logic [NCH-1:0]              sat_flag;
  logic                        frame_done;

  modport master (
    output scaled_coeff, en_sync_in, cnt_sync_in, para_in,
    input  en_sync_out, cnt_sync_out, para_out, max_out, sat_flag, frame_done
  );
  modport slave (
    input  scaled_coeff, en_sync_in, cnt_sync_in, para_in,
    output en_sync_out, cnt_sync_out, para_out, max_out, sat_flag, frame_done
  );
endinterface

// File: rtl/multi_ch_digital_gain_lane.sv
// One channel: S1 capture, S2 multiply, S3 round/saturate, plus frame peak/sticky-sat tracking.
module gain_lane import gkt_dsp_pkg::*; #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int COEFF_FRAC = 20,
  parameter bit IS_SIGNED  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    samp_i,
  input  logic [COEFF_W-1:0] coeff_i,
  input  logic               vld_s2_i,
  input  logic               stat_en_i,
  input  logic               stat_clr_i,
  input  logic               pub_i,
  output logic [OUT_W-1:0]   out_o,
  output logic [IN_W-1:0]    max_o,
  output logic               sat_o
);
  localparam int PW = prod_w(IN_W);
  localparam logic signed [PW-1:0] RND = PW'(1) << (COEFF_FRAC - 1);
  localparam logic [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] MOST_POS = ~MOST_NEG;

  logic [IN_W-1:0]       samp_q;
  logic [COEFF_W-1:0]    coeff_q;
  logic                  samp_neg;
  logic signed [PW-1:0]  prod_d, prod_q;
  logic [IN_W-1:0]       abs_d, abs_q;
  logic signed [PW-1:0]  rnd, shr;
  logic                  fits;
  logic [OUT_W-1:0]      sat_val, out_d, out_q;
  logic [IN_W-1:0]       peak_d, peak_q, max_q;
  logic                  sticky_d, sticky_q, sat_q;

  assign samp_neg = IS_SIGNED && samp_q[IN_W-1];

  always_comb begin
    prod_d = $signed({{(PW-IN_W){samp_neg}}, samp_q}) *
             $signed({{(PW-COEFF_W){1'b0}}, coeff_q});
    abs_d = samp_q;
    if (samp_neg) abs_d = (samp_q == MOST_NEG) ? MOST_POS : (~samp_q + IN_W'(1));
  end

  // Fits when every bit above the output range matches the result's sign.
  always_comb begin
    rnd = prod_q + RND;
    shr = rnd >>> COEFF_FRAC;
    if (IS_SIGNED) begin
      fits    = (&shr[PW-1:OUT_W-1]) | ~(|shr[PW-1:OUT_W-1]);
      sat_val = shr[PW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      fits    = ~(|shr[PW-1:OUT_W]);
      sat_val = shr[PW-1] ? '0 : '1;
    end
    out_d = fits ? shr[OUT_W-1:0] : sat_val;
  end

  always_comb begin
    peak_d   = stat_clr_i ? '0 : peak_q;
    sticky_d = stat_clr_i ? 1'b0 : sticky_q;
    if (stat_en_i) begin
      if (abs_q > peak_d) peak_d = abs_q;
      sticky_d = sticky_d | ~fits;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= '0;
      coeff_q  <= '0;
      prod_q   <= '0;
      abs_q    <= '0;
      out_q    <= '0;
      peak_q   <= '0;
      sticky_q <= 1'b0;
      max_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      samp_q   <= samp_i;
      coeff_q  <= coeff_i;
      prod_q   <= prod_d;
      abs_q    <= abs_d;
      if (vld_s2_i) out_q <= out_d;
      peak_q   <= peak_d;
      sticky_q <= sticky_d;
      if (pub_i) begin
        max_q <= peak_q;
        sat_q <= sticky_q;
      end
    end
  end

  assign out_o = out_q;
  assign max_o = max_q;
  assign sat_o = sat_q;
endmodule

// File: rtl/multi_ch_digital_gain.sv
// Multi-channel gain: shadow coeff per frame, 3-stage lanes, frame stats published after frame end.
module multi_ch_digital_gain import gkt_dsp_pkg::*; #(
  parameter int             NCH         = 4,
  parameter int             IN_W        = 32,
  parameter int             OUT_W       = 16,
  parameter int             COEFF_FRAC  = 20,
  parameter logic [NCH-1:0] SIGNED_MASK = DEF_SIGNED_MASK[NCH-1:0],
  parameter int             FFT_POINT   = 512,
  localparam int            CNT_W       = cnt_w(FFT_POINT)
) (
  input  logic                   clk,
  input  logic                   rst,
  multi_ch_digital_gain_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FFT_POINT - 1);

  logic [3:1]                  vld_pipe_q;
  logic [3:1][CNT_W-1:0]       cnt_pipe_q;
  logic                        init_q;
  logic [NCH-1:0][COEFF_W-1:0] shadow_q, eff_coeff;
  logic                        sof_in, sof2, eof2;
  logic                        in_frame_d, in_frame_q;
  logic                        pub_d, pub_q, done_q;
  logic                        stat_en, stat_clr;
  logic [NCH-1:0][OUT_W-1:0]   para_out;
  logic [NCH-1:0][IN_W-1:0]    max_out;
  logic [NCH-1:0]              sat_flag;

  // A frame-start sample uses the coeff presented alongside it, not the stale shadow.
  assign sof_in    = bus.en_sync_in && (bus.cnt_sync_in == '0);
  assign eff_coeff = (init_q || sof_in) ? bus.scaled_coeff : shadow_q;

  // Stats are committed as a sample moves from S2 into S3.
  assign sof2       = vld_pipe_q[2] && (cnt_pipe_q[2] == '0);
  assign eof2       = vld_pipe_q[2] && (cnt_pipe_q[2] == LAST);
  assign stat_en    = vld_pipe_q[2] && (in_frame_q || sof2);
  assign stat_clr   = pub_q || sof2;
  assign pub_d      = eof2 && (in_frame_q || sof2);
  assign in_frame_d = eof2 ? 1'b0 : (sof2 ? 1'b1 : in_frame_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      cnt_pipe_q <= '0;
      init_q     <= 1'b1;
      shadow_q   <= '0;
      in_frame_q <= 1'b0;
      pub_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[2:1], bus.en_sync_in};
      cnt_pipe_q <= {cnt_pipe_q[2:1], bus.cnt_sync_in};
      init_q     <= 1'b0;
      shadow_q   <= eff_coeff;
      in_frame_q <= in_frame_d;
      pub_q      <= pub_d;
      done_q     <= pub_q;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    gain_lane #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .COEFF_FRAC (COEFF_FRAC),
      .IS_SIGNED  (SIGNED_MASK[k])
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .samp_i     (bus.para_in[k]),
      .coeff_i    (eff_coeff[k]),
      .vld_s2_i   (vld_pipe_q[2]),
      .stat_en_i  (stat_en),
      .stat_clr_i (stat_clr),
      .pub_i      (pub_q),
      .out_o      (para_out[k]),
      .max_o      (max_out[k]),
      .sat_o      (sat_flag[k])
    );
  end

  assign bus.en_sync_out  = vld_pipe_q[3];
  assign bus.cnt_sync_out = cnt_pipe_q[3];
  assign bus.para_out     = para_out;
  assign bus.max_out      = max_out;
  assign bus.sat_flag     = sat_flag;
  assign bus.frame_done   = done_q;
endmodule

// File: doc/multi_ch_digital_gain.md
MULTI_CH_DIGITAL_GAIN -- requirements
Module: multi_ch_digital_gain

Interface
REQ-001 Parameter NCH, default 4: number of gain channels (1..8).
REQ-002 Parameter IN_W, default 32: input sample width per channel.
REQ-003 Parameter OUT_W, default 16: output sample width per channel.
REQ-004 Parameter COEFF_FRAC, default 20: right shift applied to the product, i.e. fractional bits of (sample x coeff).
REQ-005 Parameter SIGNED_MASK, default 4'b1110: bit k=1 treats channel k as two's-complement (Q/U/V); 0 treats it as unsigned (I).
REQ-006 Parameter FFT_POINT, default 512: samples per frame; CNT_W = clog2(FFT_POINT)+2.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 scaled_coeff  in  NCH*16  per-channel unsigned gain coefficient, channel k at [16k+15:16k].
REQ-010 en_sync_in  in  1  input sample valid.
REQ-011 cnt_sync_in  in  CNT_W  bin index of the current sample.
REQ-012 para_in  in  NCH*IN_W  input samples, channel k at [IN_W*k +: IN_W].
REQ-013 en_sync_out  out  1  output valid.
REQ-014 cnt_sync_out  out  CNT_W  bin index aligned with para_out.
REQ-015 para_out  out  NCH*OUT_W  gained, rounded, saturated samples.
REQ-016 max_out  out  NCH*IN_W  per-channel peak magnitude of the previous complete frame.
REQ-017 sat_flag  out  NCH  per-channel flag: at least one saturation occurred in the previous complete frame.
REQ-018 frame_done  out  1  one-cycle pulse when max_out and sat_flag update.

Function
REQ-019 Frame start is en_sync_in=1 with cnt_sync_in=0; frame end is en_sync_in=1 with cnt_sync_in=FFT_POINT-1.
REQ-020 scaled_coeff is captured into a shadow register on reset release and at each frame start; the captured value applies to that sample and to every later sample up to the next frame start.
REQ-021 Pipeline: S1 registers samples and the shadow coeff; S2 multiplies to IN_W+17 bits (signed or unsigned per SIGNED_MASK, coeff always zero-extended); S3 rounds and saturates.
REQ-022 Rounding: add 2^(COEFF_FRAC-1), then arithmetic shift right by COEFF_FRAC (round half up toward +inf).
REQ-023 Saturation: signed channels clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; unsigned channels clamp to [0, 2^OUT_W-1].
REQ-024 Latency is exactly 3 cycles: en_sync_out and cnt_sync_out are en_sync_in and cnt_sync_in delayed by 3, aligned with para_out.
REQ-025 When en_sync_in=0 the pipeline still advances; para_out keeps its last valid value while en_sync_out=0.
REQ-026 The peak tracker takes |sample| (the raw input, not the gained value) for each valid sample; the most negative signed input saturates to 2^(IN_W-1)-1.
REQ-027 On the cycle after a frame-end sample leaves S3: max_out is loaded from the running peak, sat_flag from the sticky saturation bits, frame_done pulses for 1 cycle, and the running peak and sticky bits clear to 0.
REQ-028 A frame start arriving without a preceding frame end (truncated frame) clears the running peak and sticky bits without publishing them; frame_done stays 0.
REQ-029 Frame-end and frame-start samples in consecutive cycles are both processed with no lost sample.
REQ-030 Samples before the first frame start after reset are output as normal but are excluded from peak and saturation statistics.

Reset
REQ-031 While rst=1: en_sync_out=0, cnt_sync_out=0, para_out=0, max_out=0, sat_flag=0, frame_done=0, pipeline valid bits=0, running peak=0, sticky bits=0.
REQ-032 Reset asserted mid-frame discards all in-flight samples; the first frame start after release begins statistics afresh.

Structure
REQ-033 A shared package gkt_dsp_pkg holds CNT_W derivation, the round/saturate width helper constants, and the default SIGNED_MASK.
REQ-034 One sub-module, gain_lane, implements one channel's S1-S3 datapath plus peak/sticky tracking, instantiated NCH times via generate; the top holds sync delay, frame detection and the shadow coeff.

Verification
REQ-035 Unsigned ch0, coeff=0x0010 (1<<4), COEFF_FRAC=4, input 1000 -> para_out ch0=1000 exactly 3 cycles later, with en_sync_out aligned.
REQ-036 Signed ch1, COEFF_FRAC=20, coeff=0xFFFF, input 0x7FFFFFFF -> output 32767 and sat_flag[1]=1 after frame end; input 0x80000000 -> output -32768.
REQ-037 Coeff changed from 0x0100 to 0x0200 mid-frame at cnt=100 -> gain unchanged until the next cnt=0 sample, which and later samples are doubled.
REQ-038 Frame with ch2 inputs {5,-900,300} -> max_out ch2=900 and frame_done a single pulse one cycle after the cnt=511 sample exits; the next frame starts from peak 0.
REQ-039 rst asserted at cnt=200 for 2 cycles -> all outputs 0 the cycle after; no frame_done until a full frame 0..511 completes.
REQ-040 Truncated frame (cnt 0..300, then cnt=0) -> no frame_done; max_out retains the prior frame's values.
